life_board_ctrl: RTL

//  Sequencer on the far side of two 8x8 serial board arrays (A, B). Drives the shared

---
 rtl/life_pkg.sv | 24 ++
 rtl/life_board_ctrl_if.sv | 45 ++++
 rtl/life_rule.sv | 21 ++
 rtl/life_board_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants, FSM state type and neighbour tap positions for the life board sequencer.
package life_pkg;

  localparam int CELLS = 64;
  localparam int IDX_W = $clog2(CELLS);

  // Bit positions inside the 8-bit tap bus {lu,u,ru,l,r,ld,d,rd}
  localparam int LU = 7;
  localparam int U  = 6;
  localparam int RU = 5;
  localparam int L  = 4;
  localparam int R  = 3;
  localparam int LD = 2;
  localparam int D  = 1;
  localparam int RD = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STEP,
    READ
  } state_t;

endpackage

// File: rtl/life_board_ctrl_if.sv
// Host-side command, load-stream and readout-stream bundle of the life board sequencer.
// Optional pop[6:0] live-cell count is present when LIFE_POPCOUNT_EN is defined.
interface life_board_ctrl_if #(
  parameter int GEN_W = 8
) ();

  logic             cmd_load;
  logic             cmd_step;
  logic             cmd_read;
  logic             cmd_abort;
  logic [GEN_W-1:0] gen_n;
  logic             ld_valid;
  logic             ld_bit;
  logic             ld_ready;
  logic             rd_valid;
  logic             rd_bit;
  logic             rd_ready;
  logic             busy;
  logic             done;
  logic             active_b;
`ifdef LIFE_POPCOUNT_EN
  logic [6:0]       pop;

  modport master (
    output cmd_load, cmd_step, cmd_read, cmd_abort, gen_n, ld_valid, ld_bit, rd_ready,
    input  ld_ready, rd_valid, rd_bit, busy, done, active_b, pop
  );

  modport slave (
    input  cmd_load, cmd_step, cmd_read, cmd_abort, gen_n, ld_valid, ld_bit, rd_ready,
    output ld_ready, rd_valid, rd_bit, busy, done, active_b, pop
  );
`else
  modport master (
    output cmd_load, cmd_step, cmd_read, cmd_abort, gen_n, ld_valid, ld_bit, rd_ready,
    input  ld_ready, rd_valid, rd_bit, busy, done, active_b
  );

  modport slave (
    input  cmd_load, cmd_step, cmd_read, cmd_abort, gen_n, ld_valid, ld_bit, rd_ready,
    output ld_ready, rd_valid, rd_bit, busy, done, active_b
  );
`endif

endinterface

// File: rtl/life_rule.sv
// Combinational life rule: count live neighbours and look the next cell state up in
// the birth/survive masks.
module life_rule
  import life_pkg::*;
#(
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
  input  logic       i_cur,
  input  logic [7:0] i_nbr,
  output logic       o_next
);

  logic [3:0] w_cnt;

  assign w_cnt = 4'(i_nbr[LU]) + 4'(i_nbr[U])  + 4'(i_nbr[RU]) + 4'(i_nbr[L])
               + 4'(i_nbr[R])  + 4'(i_nbr[LD]) + 4'(i_nbr[D])  + 4'(i_nbr[RD]);

  assign o_next = i_cur ? SURVIVE_MASK[w_cnt] : BIRTH_MASK[w_cnt];

endmodule

// File: rtl/life_board_ctrl.sv
// Sequencer for two 8x8 serial board arrays: load, ping-pong generation stepping, readout.
// Define LIFE_POPCOUNT_EN to add the live-cell counter on host.pop.
module life_board_ctrl
  import life_pkg::*;
#(
  parameter int         GEN_W        = 8,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] arr_cnt,
  output logic             a_data_in,
  input  logic             a_data_out,
  input  logic [7:0]       a_nbr,
  output logic             b_data_in,
  input  logic             b_data_out,
  input  logic [7:0]       b_nbr,
  life_board_ctrl_if.slave host
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [GEN_W-1:0] r_gen_left;
  logic             r_active_b;
  logic             r_abort_pend;
  logic             r_done;

  logic             w_src_out;
  logic [7:0]       w_src_nbr;
  logic             w_next;
  logic             w_slot;
  logic             w_ld_hs;
  logic             w_rd_hs;

  // The active array is always the source; during STEP the other one is the destination.
  assign w_src_out = r_active_b ? b_data_out : a_data_out;
  assign w_src_nbr = r_active_b ? b_nbr : a_nbr;
  assign w_slot    = (r_cnt == r_idx);
  assign w_ld_hs   = (r_state == LOAD) && w_slot && host.ld_valid;
  assign w_rd_hs   = (r_state == READ) && w_slot && host.rd_ready;

  life_rule #(
    .BIRTH_MASK   (BIRTH_MASK),
    .SURVIVE_MASK (SURVIVE_MASK)
  ) u_rule (
    .i_cur  (w_src_out),
    .i_nbr  (w_src_nbr),
    .o_next (w_next)
  );

  assign arr_cnt       = r_cnt;
  assign host.ld_ready = (r_state == LOAD) && w_slot;
  assign host.rd_valid = (r_state == READ) && w_slot;
  assign host.rd_bit   = w_src_out;
  assign host.busy     = (r_state != IDLE);
  assign host.done     = r_done;
  assign host.active_b = r_active_b;

  // NOTE: both outputs get their recirculate default before any override, so no latch forms.
  always_comb begin
    a_data_in = a_data_out;
    b_data_in = b_data_out;
    if (w_ld_hs) begin
      if (r_active_b) b_data_in = host.ld_bit;
      else            a_data_in = host.ld_bit;
    end
    if (r_state == STEP) begin
      if (r_active_b) a_data_in = w_next;
      else            b_data_in = w_next;
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_gen_left   <= '0;
      r_active_b   <= 1'b0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + IDX_W'(1);
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_idx        <= '0;
          r_abort_pend <= 1'b0;
          if (host.cmd_load) begin
            r_state <= LOAD;
          end else if (host.cmd_step) begin
            if (host.gen_n == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state    <= STEP;
              r_gen_left <= host.gen_n;
            end
          end else if (host.cmd_read) begin
            r_state <= READ;
          end
        end
        LOAD, READ: begin
          // The last handshake and abort both finish here, so one done pulse covers both.
          if (((w_ld_hs || w_rd_hs) && (r_idx == LAST_IDX)) || host.cmd_abort) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (w_ld_hs || w_rd_hs) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        STEP: begin
          if (host.cmd_abort) r_abort_pend <= 1'b1;
          if (r_idx == LAST_IDX) begin
            r_active_b <= ~r_active_b;
            r_gen_left <= r_gen_left - GEN_W'(1);
            r_idx      <= '0;
            if ((r_gen_left == GEN_W'(1)) || r_abort_pend || host.cmd_abort) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef LIFE_POPCOUNT_EN
  logic [6:0] r_pop;
  logic [6:0] r_pop_acc;
  logic [6:0] w_pop_nxt;

  assign w_pop_nxt = r_pop_acc + 7'((r_state == STEP) ? w_next : (w_ld_hs & host.ld_bit));
  assign host.pop  = r_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop     <= '0;
      r_pop_acc <= '0;
    end else begin
      case (r_state)
        IDLE: r_pop_acc <= '0;
        LOAD: begin
          r_pop_acc <= w_pop_nxt;
          if ((w_ld_hs && (r_idx == LAST_IDX)) || host.cmd_abort) r_pop <= w_pop_nxt;
        end
        STEP: begin
          if (r_idx == LAST_IDX) begin
            r_pop     <= w_pop_nxt;
            r_pop_acc <= '0;
          end else begin
            r_pop_acc <= w_pop_nxt;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
